// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the word-addressed instruction memory.
// Receives a byte stream (16-bit word count, then count 32-bit words, MSB first)
// and writes each assembled word to sequential word-aligned byte addresses from 0.
// The processor is held in reset until the image has loaded successfully.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   start      one-cycle pulse; re-arms the loader when in DONE
//   in_data    stream byte
//   in_valid   in_data is valid
//   in_ready   loader accepts a byte this cycle
//   we         instruction memory write enable (one cycle per word)
//   a          write byte address, word aligned
//   wd         write data (assembled word)
//   cpu_reset  holds the processor in reset
//   done       image loaded successfully
//   err        count exceeded DEPTH, nothing written
module imem_loader #(
    parameter int unsigned DEPTH = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] a,
    output logic [31:0] wd,
    output logic        cpu_reset,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {StCntHi, StCntLo, StData, StWrite, StDone} state_e;

    localparam logic [15:0] DepthW = 16'(DEPTH);

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] index_q, index_d;
    logic [1:0]  byte_q, byte_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] a_q, a_d;
    logic        err_q, err_d;
    logic        accept;
    logic [15:0] count_full;
    logic [15:0] index_inc;

    assign in_ready = ~reset &
                      ((state_q == StCntHi) | (state_q == StCntLo) | (state_q == StData));
    assign accept     = in_valid & in_ready;
    assign count_full = {count_q[15:8], in_data};
    assign index_inc  = index_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StCntHi;
            count_q <= '0;
            index_q <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            wd_q    <= '0;
            a_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            wd_q    <= wd_d;
            a_q     <= a_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        wd_d    = wd_q;
        a_d     = a_q;
        err_d   = err_q;
        case (state_q)
            StCntHi: begin
                if (accept) begin
                    count_d[15:8] = in_data;
                    state_d       = StCntLo;
                end
            end
            StCntLo: begin
                if (accept) begin
                    count_d[7:0] = in_data;
                    if (count_full == 16'd0) begin
                        state_d = StDone;
                    end else if (count_full > DepthW) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        index_d = '0;
                        byte_d  = '0;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    shift_d = {shift_q[23:0], in_data};
                    byte_d  = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        // Latch the outputs here so a/wd stay stable outside WRITE.
                        wd_d    = {shift_q[23:0], in_data};
                        a_d     = {14'b0, index_q, 2'b00};
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                index_d = index_inc;
                state_d = (index_inc == count_q) ? StDone : StData;
            end
            StDone: begin
                if (start) begin
                    err_d   = 1'b0;
                    state_d = StCntHi;
                end
            end
            default: state_d = StCntHi;
        endcase
    end

    assign we        = (state_q == StWrite);
    assign a         = a_q;
    assign wd        = wd_q;
    assign err       = err_q;
    assign done      = (state_q == StDone) & ~err_q;
    assign cpu_reset = ~done;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int Depth = 128;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, we, cpu_reset, done, err;
    logic [31:0] a, wd;

    imem_loader #(.DEPTH(Depth)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .we(we), .a(a), .wd(wd), .cpu_reset(cpu_reset),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Write monitor: every we cycle observed, plus state one cycle after each we.
    logic [31:0] got_a[$];
    logic [31:0] got_wd[$];
    int          we_ready_bad = 0;
    logic        prev_we = 1'b0;
    logic        post_done = 1'b0;
    logic        post_cpu = 1'b1;

    always @(negedge clk) begin
        if (we) begin
            got_a.push_back(a);
            got_wd.push_back(wd);
            if (in_ready) we_ready_bad++;
        end
        if (prev_we && !we) begin
            post_done = done;
            post_cpu  = cpu_reset;
        end
        prev_we = we;
    end

    // Called at a negedge; returns at the negedge after the byte was taken.
    // gap < 0 picks a random idle gap of 0..2 cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        int g;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ready_timeout", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        repeat (g) @(negedge clk);
    endtask

    // Reference model: parse the stream into the expected write list and final flags.
    task automatic run_load(input logic [7:0] s[$], input int gap, input string tag);
        logic [31:0] ea[$];
        logic [31:0] ew[$];
        int cnt, nsend, n;
        bit ok;
        cnt = int'({s[0], s[1]});
        ok  = (cnt <= Depth);
        for (int i = 0; ok && i < cnt; i++) begin
            ea.push_back(32'(i * 4));
            ew.push_back({s[2 + 4 * i], s[3 + 4 * i], s[4 + 4 * i], s[5 + 4 * i]});
        end
        nsend = ok ? 2 + 4 * cnt : 2;
        got_a.delete();
        got_wd.delete();
        we_ready_bad = 0;
        post_done = 1'b0;
        post_cpu  = 1'b1;
        for (int k = 0; k < nsend; k++) send_byte(s[k], gap);
        n = 0;
        while (!(done || err) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check($sformatf("%s_nwrites", tag), 32'(got_a.size()), 32'(ea.size()));
        for (int i = 0; i < ea.size() && i < got_a.size(); i++) begin
            check($sformatf("%s_a%0d", tag, i), got_a[i], ea[i]);
            check($sformatf("%s_wd%0d", tag, i), got_wd[i], ew[i]);
        end
        check($sformatf("%s_done", tag), {31'b0, done}, {31'b0, ok});
        check($sformatf("%s_err", tag), {31'b0, err}, {31'b0, !ok});
        check($sformatf("%s_cpu_reset", tag), {31'b0, cpu_reset}, {31'b0, !ok});
        check($sformatf("%s_ready_in_write", tag), 32'(we_ready_bad), 32'd0);
        if (ok && cnt > 0) begin
            check($sformatf("%s_done_after_we", tag), {31'b0, post_done}, 32'd1);
            check($sformatf("%s_cpu_after_we", tag), {31'b0, post_cpu}, 32'd0);
        end
    endtask

    task automatic rearm(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("%s_cpu_reset_rise", tag), {31'b0, cpu_reset}, 32'd1);
        check($sformatf("%s_done_clear", tag), {31'b0, done}, 32'd0);
        check($sformatf("%s_err_clear", tag), {31'b0, err}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_we"}, {31'b0, we}, 32'd0);
        check({tag, "_a"}, a, 32'd0);
        check({tag, "_wd"}, wd, 32'd0);
        check({tag, "_cpu_reset"}, {31'b0, cpu_reset}, 32'd1);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    endtask

    logic [7:0] s[$];
    int         cnt;

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_ready", {31'b0, in_ready}, 32'd1);

        // Directed three-word image, back-to-back bytes.
        s = '{8'h00, 8'h03, 8'hE0, 8'h4F, 8'h00, 8'h0F, 8'hE2, 8'h80, 8'h20, 8'h05,
              8'hE2, 8'h43, 8'h70, 8'h09};
        run_load(s, 0, "img3");

        // Same image, in_valid 1 on / 2 off.
        rearm("re1");
        run_load(s, 2, "img3gap");

        // Randomized images with random gaps.
        for (int it = 0; it < 4; it++) begin
            rearm($sformatf("rr%0d", it));
            cnt = $urandom_range(1, 6);
            s = '{8'h00, 8'(cnt)};
            for (int k = 0; k < 4 * cnt; k++) s.push_back(8'($urandom));
            run_load(s, -1, $sformatf("rnd%0d", it));
        end

        // Empty image.
        rearm("re2");
        s = '{8'h00, 8'h00};
        run_load(s, 0, "cnt0");

        // Oversized count.
        rearm("re3");
        s = '{8'h00, 8'h81};
        run_load(s, 0, "cnt129");
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("err_ready%0d", k), {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("err_no_we", 32'(got_a.size()), 32'd0);

        // Reset in the middle of the first word.
        rearm("re4");
        got_a.delete();
        got_wd.delete();
        s = '{8'h00, 8'h01, 8'hAB, 8'hCD};
        for (int k = 0; k < 4; k++) send_byte(s[k], 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        reset = 1'b0;
        @(negedge clk);
        check("midrst_no_we", 32'(got_a.size()), 32'd0);
        s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        run_load(s, 0, "reload");

        // Full-depth image: final address must be (DEPTH-1)*4.
        rearm("re5");
        s = '{8'h00, 8'(Depth)};
        for (int k = 0; k < 4 * Depth; k++) s.push_back(8'($urandom));
        run_load(s, 0, "full");
        check("full_last_a", a, 32'((Depth - 1) * 4));

        // Re-arm after success and load a single word.
        rearm("re6");
        s = '{8'h00, 8'h01, 8'hEA, 8'hFF, 8'hFF, 8'hFE};
        run_load(s, 0, "one");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
